serial_word_loader: RTL and testbench
=====================================

SERIAL_WORD_LOADER -- requirements
Module: serial_word_loader

Interface
REQ-001 SHALL have parameter WIDTH, default 4, word width written to register file.
REQ-002 SHALL have parameter DEPTH, default 4, words per frame (power of two); AW = $clog2(DEPTH).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port start  input  1  begins a frame when sampled high in IDLE.
REQ-006 SHALL have port ser_valid  input  1  serial bit present on ser_in.
REQ-007 SHALL have port ser_in  input  1  serial data bit.
REQ-008 SHALL have port ser_ready  output  1  high only in SHIFT; bit accepted when ser_valid && ser_ready.
REQ-009 SHALL have port en  output  1  register-file write enable (drives register_file en).
REQ-010 SHALL have port waddr  output  AW  register-file write address.
REQ-011 SHALL have port wdata  output  WIDTH  register-file write data.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port done  output  1  one-cycle pulse on frame completion.

Function
REQ-014 SHALL implement FSM states IDLE, SHIFT, WRITE, DONE.
REQ-015 IDLE: start=1 -> SHIFT next cycle; bit counter and word address cleared to 0.
REQ-016 SHIFT: each accepted bit shifts into the shift register and increments bit counter; ser_valid=0 holds all state (no timeout).
REQ-017 SHIFT: acceptance of the WIDTH-th bit -> WRITE next cycle, bit counter wraps to 0.
REQ-018 WRITE: en=1 for exactly one cycle, waddr=current word address, wdata=assembled word; ser_ready=0, ser_in ignored.
REQ-019 WRITE: address < DEPTH-1 -> address increments, SHIFT next; address == DEPTH-1 -> DONE next, address not incremented.
REQ-020 DONE: done=1 for one cycle -> IDLE unconditionally.
REQ-021 Latency: en asserts the cycle after the last bit of a word is accepted; done asserts the cycle after the final write.
REQ-022 start while busy=1 SHALL be ignored; start and ser_valid both high in IDLE: only start acts.
REQ-023 en SHALL never be high outside WRITE; waddr/wdata SHALL hold last values when en=0.
REQ-024 Default bit order LSB-first: first accepted bit of a word lands in wdata[0].

Reset
REQ-025 rst_n low SHALL asynchronously force IDLE; en, done, busy, ser_ready, waddr, wdata, counters all 0.
REQ-026 Reset mid-frame SHALL abandon partial word with no write; next frame restarts at address 0.

Configuration
REQ-027 Macro SHIFT_MSB_FIRST_EN defined: first accepted bit lands in wdata[WIDTH-1] (MSB-first); undefined: LSB-first per REQ-024. No other behaviour changes.

Structure
REQ-028 Package loader_pkg SHALL hold the state enum (IDLE, SHIFT, WRITE, DONE) and default WIDTH/DEPTH constants.
REQ-029 Shift register SHALL be sub-module sipo_shift_reg (clk, rst_n, shift_en, ser_in, q[WIDTH-1:0]), bit order selected by the macro.

Verification
REQ-030 Reset then start, LSB-first stream of 16 bits encoding 1111,0101,1101,0111 -> en pulses at addr 00,01,10,11 with those wdata; done one cycle after 4th write; register_file raddr=10 reads 1101.
REQ-031 ser_valid gaps of 3 cycles between bits -> identical writes, no extra en pulses, ser_ready high throughout SHIFT.
REQ-032 start pulsed mid-frame and ser_valid held high during WRITE -> no restart, dropped bits not shifted, addresses unchanged sequence.
REQ-033 rst_n low after 2 bits of word 2 -> outputs 0 immediately (async); new frame writes from addr 00.
REQ-034 With SHIFT_MSB_FIRST_EN, serial 1,1,0,1 -> wdata 1101; without it -> wdata 1011.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared types and defaults for the serial word loader.
// The state encoding is common to the loader FSM and any checker modules.
package loader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_DEPTH = 4;

endpackage

// File: rtl/sipo_shift_reg.sv
// Serial-in parallel-out shift register that assembles one word.
// Bit order: LSB-first by default, MSB-first when SHIFT_MSB_FIRST_EN is defined.
module sipo_shift_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q
);

  // Shift one accepted bit in; the first bit of a word ends at the selected end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= {WIDTH{1'b0}};
    end else if (shift_en) begin
`ifdef SHIFT_MSB_FIRST_EN
      q <= {q[WIDTH-2:0], ser_in};
`else
      q <= {ser_in, q[WIDTH-1:1]};
`endif
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/serial_word_loader.sv
// Collects DEPTH serial words of WIDTH bits and writes each one to a register file.
// Bit order follows SHIFT_MSB_FIRST_EN (see sipo_shift_reg); nothing else depends on it.
module serial_word_loader
  import loader_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             ser_valid,
  input  logic             ser_in,
  output logic             ser_ready,
  output logic             en,
  output logic [AW-1:0]    waddr,
  output logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e            state_r, state_s;
  logic [CW-1:0]     cnt_r, cnt_s;
  logic [AW-1:0]     addr_r, addr_s;
  logic [AW-1:0]     waddr_r;
  logic [WIDTH-1:0]  wdata_r;
  logic [WIDTH-1:0]  q_s;
  logic              accept_s;
  logic              ready_r, en_r, busy_r, done_r;

  // ser_ready is a registered decode of SHIFT, so acceptance never happens elsewhere.
  assign accept_s = ser_valid && ready_r;

  sipo_shift_reg #(.WIDTH(WIDTH)) u_sipo (
    .clk      (clk),
    .rst_n    (rst_n),
    .shift_en (accept_s),
    .ser_in   (ser_in),
    .q        (q_s)
  );

  // Next-state, bit counter and word address.
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    addr_s  = addr_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = SHIFT;
          cnt_s   = {CW{1'b0}};
          addr_s  = {AW{1'b0}};
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        if (accept_s) begin
          if (cnt_r == CW'(WIDTH - 1)) begin
            cnt_s   = {CW{1'b0}};
            state_s = WRITE;
          end else begin
            cnt_s = cnt_r + CW'(1);
          end
        end else begin
          state_s = SHIFT;
        end
      end
      WRITE: begin
        if (addr_r == AW'(DEPTH - 1)) begin
          state_s = DONE;
        end else begin
          addr_s  = addr_r + AW'(1);
          state_s = SHIFT;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State, counters and registered status outputs decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      cnt_r   <= {CW{1'b0}};
      addr_r  <= {AW{1'b0}};
      ready_r <= 1'b0;
      en_r    <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      addr_r  <= addr_s;
      ready_r <= (state_s == SHIFT);
      en_r    <= (state_s == WRITE);
      busy_r  <= (state_s != IDLE);
      done_r  <= (state_s == DONE);
    end
  end

  // Write address is captured on entry to WRITE and then held until the next word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      waddr_r <= {AW{1'b0}};
      wdata_r <= {WIDTH{1'b0}};
    end else begin
      waddr_r <= (state_s == WRITE) ? addr_r : waddr_r;
      wdata_r <= (state_r == WRITE) ? q_s : wdata_r;
    end
  end

  // The shift register already holds the finished word during WRITE; outside it the
  // last written word is presented so wdata stays stable while the next word shifts in.
  assign wdata     = (state_r == WRITE) ? q_s : wdata_r;
  assign waddr     = waddr_r;
  assign en        = en_r;
  assign ser_ready = ready_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_serial_word_loader.sv
// Directed self-checking bench for serial_word_loader (either SHIFT_MSB_FIRST_EN build).
module tb_serial_word_loader;

  localparam int WIDTH = 4;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             start = 1'b0;
  logic             ser_valid = 1'b0;
  logic             ser_in = 1'b0;
  logic             ser_ready;
  logic             en;
  logic [1:0]       waddr;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;

  always #5 clk = ~clk;

  serial_word_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .ser_valid (ser_valid),
    .ser_in    (ser_in),
    .ser_ready (ser_ready),
    .en        (en),
    .waddr     (waddr),
    .wdata     (wdata),
    .busy      (busy),
    .done      (done)
  );

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_en_cyc = 0;
  int   frame_wr = 0;
  logic noisy = 1'b0;
  logic [3:0] mem [4];
  logic [3:0] exp_words [4];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Stream bits go out w[0] first; the loaded word depends on the bit-order build.
  function automatic logic [3:0] exp_of(input logic [3:0] w);
`ifdef SHIFT_MSB_FIRST_EN
    return {w[0], w[1], w[2], w[3]};
`else
    return w;
`endif
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Register-file model and write/done monitor.
  always @(negedge clk) begin
    if (en) begin
      if (frame_wr < DEPTH) begin
        check("waddr", waddr, frame_wr);
        check("wdata", wdata, exp_words[frame_wr]);
      end else begin
        check("extra_en", frame_wr, DEPTH - 1);
      end
      mem[waddr] = wdata;
      frame_wr++;
      last_en_cyc = cyc;
    end
    if (done) begin
      check("done_latency", cyc - last_en_cyc, 1);
      check("done_after_writes", frame_wr, DEPTH);
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, "_en"}, en, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_ready"}, ser_ready, 0);
    check({tag, "_waddr"}, waddr, 0);
    check({tag, "_wdata"}, wdata, 0);
  endtask

  // Start and a stray serial bit together in IDLE: only start may act.
  task automatic start_frame(input logic [3:0] w0, w1, w2, w3);
    exp_words[0] = exp_of(w0);
    exp_words[1] = exp_of(w1);
    exp_words[2] = exp_of(w2);
    exp_words[3] = exp_of(w3);
    frame_wr = 0;
    @(negedge clk);
    start = 1'b1; ser_valid = 1'b1; ser_in = 1'b1;
    @(negedge clk);
    start = 1'b0; ser_valid = 1'b0;
    check("busy_after_start", busy, 1);
    check("ready_after_start", ser_ready, 1);
  endtask

  // Called on a negedge; returns on the negedge after the bit was accepted.
  task automatic send_bit(input logic b, input int gap, input bit chk_ready);
    int t = 0;
    ser_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      start = noisy;
      @(negedge clk);
      start = 1'b0;
      if (chk_ready) check("ready_in_gap", ser_ready, 1);
    end
    while (!ser_ready && t < 20) begin
      ser_valid = noisy; ser_in = ~b; start = noisy;
      @(negedge clk);
      t++;
    end
    start = 1'b0;
    if (t >= 20) check("ready_timeout", t, 0);
    ser_valid = 1'b1; ser_in = b;
    @(negedge clk);
    ser_valid = 1'b0;
  endtask

  task automatic send_word(input logic [3:0] w, input int gap);
    for (int i = 0; i < 4; i++) send_bit(w[i], gap, i > 0);
  endtask

  task automatic wait_done();
    int t = 0;
    while (!done && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("done_seen", done, 1);
    @(negedge clk);
    check("done_one_cycle", done, 0);
    check("idle_busy", busy, 0);
  endtask

  task automatic run_frame(input logic [3:0] w0, w1, w2, w3, input int gap);
    start_frame(w0, w1, w2, w3);
    send_word(w0, gap);
    send_word(w1, gap);
    send_word(w2, gap);
    send_word(w3, gap);
    wait_done();
    check("frame_writes", frame_wr, DEPTH);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Basic frame, back-to-back bits.
    run_frame(4'b1111, 4'b0101, 4'b1101, 4'b0111, 0);
    check("rf_raddr2", mem[2], exp_of(4'b1101));
    check("waddr_hold", waddr, 3);
    check("wdata_hold", wdata, exp_of(4'b0111));

    // Three idle cycles between every bit.
    run_frame(4'b1111, 4'b0101, 4'b1101, 4'b0111, 3);
    check("gap_rf_raddr1", mem[1], exp_of(4'b0101));

    // Start pulses mid-frame, garbage bits offered during WRITE.
    noisy = 1'b1;
    run_frame(4'b0011, 4'b1000, 4'b0110, 4'b1001, 1);
    noisy = 1'b0;
    check("noisy_rf_raddr3", mem[3], exp_of(4'b1001));

    // Asynchronous reset two bits into word 2.
    start_frame(4'b1111, 4'b0101, 4'b1101, 4'b0111);
    send_word(4'b1111, 0);
    send_word(4'b0101, 0);
    send_bit(1'b1, 0, 1'b0);
    send_bit(1'b0, 0, 1'b1);
    check("pre_reset_writes", frame_wr, 2);
    check("pre_reset_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    @(negedge clk);
    check("partial_not_written", frame_wr, 2);
    rst_n = 1'b1;
    run_frame(4'b1010, 4'b0001, 4'b1110, 4'b0100, 0);
    check("post_reset_raddr0", mem[0], exp_of(4'b1010));

    // Serial 1,1,0,1 gives 1011 LSB-first and 1101 MSB-first.
    run_frame(4'b1011, 4'b0000, 4'b1011, 4'b0000, 0);
`ifdef SHIFT_MSB_FIRST_EN
    check("bit_order", mem[0], 4'b1101);
`else
    check("bit_order", mem[0], 4'b1011);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
